audio_decimator: RTL

- Converts the C64 core's raw 18-bit signed stereo audio, sampled every clk32 cycle, into 16-bit signed stereo samples at exactly 48 kHz for the HDMI audio path.
- Sits directly upstream of the video/HDMI block's audio input.
- Stages: per-channel one-pole IIR low-pass anti-alias filter, then a fractional-rate 48 kHz sample tick, then rounding/saturation to 16 bits, then a one-entry valid/ready output register.

---
 rtl/audio_decimator.sv | 124 ++++++++++++
 1 files changed

// File: rtl/audio_decimator.sv
// audio_decimator: 18-bit stereo sampled every clk32 -> low-passed, rounded 16-bit stereo at RATE.
// Optional rectangular rounding dither from a 16-bit LFSR when AUDIO_DECIM_DITHER_EN is defined.
module audio_decimator #(
    parameter int unsigned CLK_HZ    = 31500000,
    parameter int unsigned RATE      = 48000,
    parameter int unsigned LPF_SHIFT = 6
) (
    input  logic               clk32,
    input  logic               reset,
    input  logic signed [17:0] audio_l,
    input  logic signed [17:0] audio_r,
    output logic signed [15:0] sample_l,
    output logic signed [15:0] sample_r,
    output logic               sample_valid,
    input  logic               sample_ready,
    output logic               overrun
);
    localparam int unsigned IN_W   = 18;
    localparam int unsigned OUT_W  = 16;
    localparam int unsigned PH_W   = 26;
    localparam int unsigned ACC_W  = IN_W + LPF_SHIFT;
    localparam int unsigned CONV_W = IN_W + 1;

    logic [PH_W-1:0]         phase;
    logic [PH_W:0]           phase_sum_c;
    logic                    tick_c;
    logic signed [ACC_W-1:0] acc_l;
    logic signed [ACC_W-1:0] acc_r;
    logic signed [IN_W-1:0]  y_l_c;
    logic signed [IN_W-1:0]  y_r_c;
    logic [1:0]              rnd_c;
    logic signed [OUT_W-1:0] pcm_l_c;
    logic signed [OUT_W-1:0] pcm_r_c;
    logic                    xfer_c;
    logic                    load_c;

    // Fractional-rate tick: exactly RATE ticks per CLK_HZ cycles
    assign phase_sum_c = {1'b0, phase} + (PH_W+1)'(RATE);
    assign tick_c      = (phase_sum_c >= (PH_W+1)'(CLK_HZ));

    always_ff @(posedge clk32 or posedge reset) begin
        if (reset) begin
            phase <= '0;
        end else if (tick_c) begin
            phase <= PH_W'(phase_sum_c - (PH_W+1)'(CLK_HZ));
        end else begin
            phase <= PH_W'(phase_sum_c);
        end
    end

    // One-pole IIR; acc holds y scaled by 2^LPF_SHIFT so steady state is bias-free
    always_ff @(posedge clk32 or posedge reset) begin
        if (reset) begin
            acc_l <= '0;
            acc_r <= '0;
        end else begin
            acc_l <= acc_l + ACC_W'(audio_l) - (acc_l >>> LPF_SHIFT);
            acc_r <= acc_r + ACC_W'(audio_r) - (acc_r >>> LPF_SHIFT);
        end
    end

    assign y_l_c = IN_W'(acc_l >>> LPF_SHIFT);
    assign y_r_c = IN_W'(acc_r >>> LPF_SHIFT);

`ifdef AUDIO_DECIM_DITHER_EN
    logic [15:0] lfsr;

    always_ff @(posedge clk32 or posedge reset) begin
        if (reset) begin
            lfsr <= 16'hACE1;
        end else if (tick_c) begin
            lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        end
    end

    assign rnd_c = lfsr[1:0];
`else
    assign rnd_c = 2'd2;
`endif

    // Round by dropping two LSBs, then clip to the 16-bit range
    function automatic logic signed [OUT_W-1:0] to_pcm(input logic signed [IN_W-1:0] y,
                                                       input logic [1:0] rnd);
        logic signed [CONV_W-1:0] rnd_s;
        logic signed [CONV_W-1:0] r;
        rnd_s = CONV_W'(rnd);
        r     = (CONV_W'(y) + rnd_s) >>> 2;
        if (r > CONV_W'(32767)) begin
            to_pcm = 16'sh7FFF;
        end else if (r < CONV_W'(-32768)) begin
            to_pcm = 16'sh8000;
        end else begin
            to_pcm = OUT_W'(r);
        end
    endfunction

    assign pcm_l_c = to_pcm(y_l_c, rnd_c);
    assign pcm_r_c = to_pcm(y_r_c, rnd_c);

    assign xfer_c = sample_valid && sample_ready;
    assign load_c = tick_c && (!sample_valid || xfer_c);

    // One-entry output register; a tick into a stalled register is dropped and flagged
    always_ff @(posedge clk32 or posedge reset) begin
        if (reset) begin
            sample_l     <= '0;
            sample_r     <= '0;
            sample_valid <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            if (load_c) begin
                sample_l     <= pcm_l_c;
                sample_r     <= pcm_r_c;
                sample_valid <= 1'b1;
            end else if (xfer_c) begin
                sample_valid <= 1'b0;
            end
            if (tick_c && sample_valid && !sample_ready) begin
                overrun <= 1'b1;
            end
        end
    end

endmodule
